// File: rtl/lcd_frame_sequencer.sv
// Byte sequencer for an ST7565-class SPI LCD: panel reset, init command list, page-wise frame refresh.
// Optional contrast port and runtime contrast update when LCD_SEQ_CONTRAST_EN is defined.
module lcd_frame_sequencer #(
  parameter int COLS       = 132,
  parameter int PAGES      = 4,
  parameter int RST_CYCLES = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       refresh,
  input  logic [3:0]                 count,
  input  logic [7:0]                 pix_data,
`ifdef LCD_SEQ_CONTRAST_EN
  input  logic [5:0]                 contrast,
`endif
  output logic [7:0]                 stream,
  output logic                       si_conv,
  output logic [7:0]                 state_next,
  output logic                       lcd_a0,
  output logic                       lcd_rst_n,
  output logic [$clog2(PAGES)-1:0]   pix_page,
  output logic [7:0]                 pix_col,
  output logic                       busy
);

  localparam int PW = $clog2(PAGES);
  localparam int RW = $clog2(RST_CYCLES + 1);

  localparam logic [7:0]    CODE_RST   = 8'h00;
  localparam logic [7:0]    CODE_INIT  = 8'h01;
  localparam logic [7:0]    CODE_IDLE  = 8'h02;
  localparam logic [7:0]    CODE_ADDR  = 8'h03;
  localparam logic [7:0]    CODE_WRITE = 8'h04;
`ifdef LCD_SEQ_CONTRAST_EN
  localparam logic [7:0]    CODE_CONTR = 8'h05;
`endif
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [7:0]    COL_LAST   = 8'(COLS - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGES - 1);
  localparam logic [7:0]    INIT_LAST  = 8'd11;

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RST_WAIT,
    S_INIT,
    S_IDLE,
    S_ADDR,
    S_WRITE,
    S_CONTR
  } state_t;

  state_t          state_reg;
  logic [RW-1:0]   rst_cnt_reg;
  logic [7:0]      idx_reg;
  logic [PW-1:0]   page_reg;
  logic            pending_reg;
  logic [7:0]      contrast_byte;
  logic [PW-1:0]   page_inc;
  logic            byte_done;

`ifdef LCD_SEQ_CONTRAST_EN
  logic [5:0]      contrast_sent_reg;
  assign contrast_byte = {2'b00, contrast};
`else
  assign contrast_byte = 8'h1F;
`endif

  assign page_inc  = page_reg + 1'b1;
  // A slot ends on count==8 while streaming; with si_conv low the FSM advances every clock.
  assign byte_done = !si_conv || (count == 4'd8);

  function automatic logic [7:0] init_byte(input logic [3:0] i, input logic [7:0] b10);
    case (i)
      4'd0:    init_byte = 8'h40;
      4'd1:    init_byte = 8'hA1;
      4'd2:    init_byte = 8'hC0;
      4'd3:    init_byte = 8'hA6;
      4'd4:    init_byte = 8'hA2;
      4'd5:    init_byte = 8'h2F;
      4'd6:    init_byte = 8'hF8;
      4'd7:    init_byte = 8'h00;
      4'd8:    init_byte = 8'h23;
      4'd9:    init_byte = 8'h81;
      4'd10:   init_byte = b10;
      default: init_byte = 8'hAF;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_RST_HOLD;
      rst_cnt_reg <= '0;
      idx_reg     <= '0;
      page_reg    <= '0;
      pending_reg <= 1'b0;
      stream      <= 8'h00;
      si_conv     <= 1'b0;
      state_next  <= CODE_RST;
      lcd_a0      <= 1'b0;
      lcd_rst_n   <= 1'b0;
      pix_page    <= '0;
      pix_col     <= 8'h00;
      busy        <= 1'b1;
`ifdef LCD_SEQ_CONTRAST_EN
      contrast_sent_reg <= 6'h00;
`endif
    end else begin
      if (refresh && state_reg != S_IDLE)
        pending_reg <= 1'b1;

      if (byte_done) begin
        case (state_reg)
          S_RST_HOLD: begin
            if (rst_cnt_reg == RST_LAST) begin
              rst_cnt_reg <= '0;
              lcd_rst_n   <= 1'b1;
              state_reg   <= S_RST_WAIT;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + 1'b1;
            end
          end

          S_RST_WAIT: begin
            if (rst_cnt_reg == RST_LAST) begin
              rst_cnt_reg <= '0;
              state_reg   <= S_INIT;
              stream      <= init_byte(4'd0, contrast_byte);
              si_conv     <= 1'b1;
              state_next  <= CODE_INIT;
              lcd_a0      <= 1'b0;
              idx_reg     <= 8'd0;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + 1'b1;
            end
          end

          S_INIT: begin
            if (idx_reg == INIT_LAST) begin
              state_reg  <= S_IDLE;
              si_conv    <= 1'b0;
              state_next <= CODE_IDLE;
              lcd_a0     <= 1'b0;
              busy       <= 1'b0;
            end else begin
              stream  <= init_byte(idx_reg[3:0] + 4'd1, contrast_byte);
              idx_reg <= idx_reg + 8'd1;
`ifdef LCD_SEQ_CONTRAST_EN
              // The init list carries the contrast value; remember what the panel got.
              if (idx_reg == 8'd9)
                contrast_sent_reg <= contrast;
`endif
            end
          end

          S_IDLE: begin
            if (refresh || pending_reg) begin
              pending_reg <= 1'b0;
              state_reg   <= S_ADDR;
              stream      <= 8'hB0;
              si_conv     <= 1'b1;
              state_next  <= CODE_ADDR;
              lcd_a0      <= 1'b0;
              busy        <= 1'b1;
              idx_reg     <= 8'd0;
              page_reg    <= '0;
              pix_page    <= '0;
              pix_col     <= 8'h00;
            end
`ifdef LCD_SEQ_CONTRAST_EN
            else if (contrast != contrast_sent_reg) begin
              state_reg         <= S_CONTR;
              stream            <= 8'h81;
              si_conv           <= 1'b1;
              state_next        <= CODE_CONTR;
              lcd_a0            <= 1'b0;
              busy              <= 1'b1;
              idx_reg           <= 8'd0;
              contrast_sent_reg <= contrast;
            end
`endif
          end

          S_ADDR: begin
            if (idx_reg == 8'd0) begin
              stream  <= 8'h10;
              idx_reg <= 8'd1;
            end else if (idx_reg == 8'd1) begin
              stream  <= 8'h00;
              idx_reg <= 8'd2;
            end else begin
              // pix_data already reflects column 0 of this page; move the prefetch on to column 1.
              state_reg  <= S_WRITE;
              stream     <= pix_data;
              state_next <= CODE_WRITE;
              lcd_a0     <= 1'b1;
              idx_reg    <= 8'd0;
              pix_col    <= 8'd1;
            end
          end

          S_WRITE: begin
            if (idx_reg == COL_LAST) begin
              if (page_reg == PAGE_LAST) begin
                state_reg  <= S_IDLE;
                si_conv    <= 1'b0;
                state_next <= CODE_IDLE;
                lcd_a0     <= 1'b0;
                busy       <= 1'b0;
                page_reg   <= '0;
              end else begin
                state_reg  <= S_ADDR;
                stream     <= 8'hB0 | 8'(page_inc);
                state_next <= CODE_ADDR;
                lcd_a0     <= 1'b0;
                idx_reg    <= 8'd0;
                page_reg   <= page_inc;
              end
            end else begin
              stream  <= pix_data;
              idx_reg <= idx_reg + 8'd1;
              // Loading the last column: the next data byte lives at column 0 of the following page.
              if (idx_reg + 8'd1 == COL_LAST) begin
                pix_col  <= 8'h00;
                pix_page <= (page_reg == PAGE_LAST) ? '0 : page_inc;
              end else begin
                pix_col <= idx_reg + 8'd2;
              end
            end
          end

`ifdef LCD_SEQ_CONTRAST_EN
          S_CONTR: begin
            if (idx_reg == 8'd0) begin
              stream  <= {2'b00, contrast_sent_reg};
              idx_reg <= 8'd1;
            end else begin
              state_reg  <= S_IDLE;
              si_conv    <= 1'b0;
              state_next <= CODE_IDLE;
              lcd_a0     <= 1'b0;
              busy       <= 1'b0;
            end
          end
`endif

          default: begin
            state_reg  <= S_IDLE;
            si_conv    <= 1'b0;
            state_next <= CODE_IDLE;
            lcd_a0     <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer with a behavioural serializer (count 0..8, optional stall).
// Define LCD_SEQ_CONTRAST_EN to also exercise the contrast update burst.
module tb_lcd_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       refresh = 1'b0;
  logic [3:0] count = 4'd0;
  logic [7:0] pix_data;
  logic [7:0] stream;
  logic       si_conv;
  logic [7:0] state_next;
  logic       lcd_a0;
  logic       lcd_rst_n;
  logic [1:0] pix_page;
  logic [7:0] pix_col;
  logic       busy;
`ifdef LCD_SEQ_CONTRAST_EN
  logic [5:0] contrast = 6'h1F;
`endif

  lcd_frame_sequencer dut (
    .clock(clock),
    .reset(reset),
    .refresh(refresh),
    .count(count),
    .pix_data(pix_data),
`ifdef LCD_SEQ_CONTRAST_EN
    .contrast(contrast),
`endif
    .stream(stream),
    .si_conv(si_conv),
    .state_next(state_next),
    .lcd_a0(lcd_a0),
    .lcd_rst_n(lcd_rst_n),
    .pix_page(pix_page),
    .pix_col(pix_col),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Serializer model: counts 0..8 per byte while enabled, freezes while stalled.
  logic stall = 1'b0;
  always @(posedge clock) begin
    if (!si_conv)
      count <= 4'd0;
    else if (!stall)
      count <= (count == 4'd8) ? 4'd0 : count + 4'd1;
  end

  // Framebuffer model: mode 0 = column index, mode 1 = column + 64*page.
  logic pix_mode = 1'b0;
  always_comb begin
    pix_data = pix_mode ? 8'(pix_col + {pix_page, 6'b0}) : pix_col;
  end

  // Byte capture: a new byte is offered when si_conv rises or a slot completes while enabled.
  int         cyc = 0;
  logic       pre_si;
  logic [3:0] pre_cnt;
  logic [7:0] cap_b[$];
  logic       cap_a0[$];
  logic [7:0] cap_sn[$];
  int         cap_c[$];
  logic [7:0] exp_b[$];
  logic       exp_a0[$];
  logic [7:0] exp_sn[$];

  always @(posedge clock) begin
    pre_si  = si_conv;
    pre_cnt = count;
    cyc     = cyc + 1;
    #1;
    if (si_conv === 1'b1 && (pre_si !== 1'b1 || pre_cnt == 4'd8)) begin
      cap_b.push_back(stream);
      cap_a0.push_back(lcd_a0);
      cap_sn.push_back(state_next);
      cap_c.push_back(cyc);
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic clear_caps();
    cap_b.delete(); cap_a0.delete(); cap_sn.delete(); cap_c.delete();
    exp_b.delete(); exp_a0.delete(); exp_sn.delete();
  endtask

  task automatic push_exp(input logic [7:0] b, input logic a0, input logic [7:0] sn);
    exp_b.push_back(b); exp_a0.push_back(a0); exp_sn.push_back(sn);
  endtask

  task automatic build_init();
    logic [7:0] rom [12];
    rom = '{8'h40, 8'hA1, 8'hC0, 8'hA6, 8'hA2, 8'h2F, 8'hF8, 8'h00, 8'h23, 8'h81, 8'h1F, 8'hAF};
    for (int i = 0; i < 12; i++) push_exp(rom[i], 1'b0, 8'h01);
  endtask

  task automatic build_frame(input bit mode);
    for (int p = 0; p < 4; p++) begin
      push_exp(8'hB0 + 8'(p), 1'b0, 8'h03);
      push_exp(8'h10, 1'b0, 8'h03);
      push_exp(8'h00, 1'b0, 8'h03);
      for (int c = 0; c < 132; c++)
        push_exp(mode ? 8'((c + 64 * p) % 256) : 8'(c), 1'b1, 8'h04);
    end
  endtask

  function automatic int first_mismatch();
    int n;
    n = (cap_b.size() < exp_b.size()) ? cap_b.size() : exp_b.size();
    for (int i = 0; i < n; i++)
      if (cap_b[i] !== exp_b[i] || cap_a0[i] !== exp_a0[i] || cap_sn[i] !== exp_sn[i])
        return i;
    if (cap_b.size() != exp_b.size()) return n;
    return -1;
  endfunction

  function automatic logic [16:0] cap_at(input int i);
    if (i < cap_b.size()) return {cap_sn[i], cap_a0[i], cap_b[i]};
    return 'x;
  endfunction

  function automatic logic [16:0] exp_at(input int i);
    if (i < exp_b.size()) return {exp_sn[i], exp_a0[i], exp_b[i]};
    return 'x;
  endfunction

  function automatic int bad_spacing(input int lo, input int hi);
    for (int i = lo + 1; i <= hi && i < cap_c.size(); i++)
      if (cap_c[i] - cap_c[i-1] != 9) return i;
    return -1;
  endfunction

  // sel: 0 rst_n high, 1 si_conv high, 2 si_conv low, 3 busy low. n = edges waited.
  task automatic wait_for(input int sel, input int limit, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < limit) begin
      @(posedge clock); #1;
      n++;
      if ((sel == 0 && lcd_rst_n === 1'b1) || (sel == 1 && si_conv === 1'b1) ||
          (sel == 2 && si_conv === 1'b0) || (sel == 3 && busy === 1'b0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_refresh(output int start_exp);
    @(negedge clock);
    refresh   = 1'b1;
    start_exp = cyc + 1;
    @(negedge clock);
    refresh   = 1'b0;
  endtask

  // Shared by the power-on and mid-frame reset scenarios: release, then reset/init timing and bytes.
  task automatic check_boot(input string tag);
    int  n;
    bit  ok;
    int  mm;
    clear_caps();
    wait_for(0, 50, n, ok);
    checks++;
    if (!ok || n != 10) $display("FAIL %s rst_low_cycles: got %0d want 10", tag, n); else passed++;
    wait_for(1, 50, n, ok);
    checks++;
    if (!ok || n != 10) $display("FAIL %s rst_wait_cycles: got %0d want 10", tag, n); else passed++;
    wait_for(2, 200, n, ok);
    checks++;
    if (!ok || n != 108) $display("FAIL %s init_cycles: got %0d want 108", tag, n); else passed++;
    build_init();
    mm = first_mismatch();
    checks++;
    if (mm >= 0)
      $display("FAIL %s init_bytes: idx %0d got %h want %h (n %0d/%0d)", tag, mm, cap_at(mm), exp_at(mm), cap_b.size(), exp_b.size());
    else passed++;
    mm = bad_spacing(0, 11);
    checks++;
    if (mm >= 0) $display("FAIL %s init_spacing: idx %0d gap %0d want 9", tag, mm, cap_c[mm] - cap_c[mm-1]); else passed++;
    checks++;
    if ({busy, state_next} !== {1'b0, 8'h02})
      $display("FAIL %s idle_after_init: got busy %b state %h want 0 02", tag, busy, state_next);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (stream !== 8'h00)     $display("FAIL rst_stream: got %h want 00", stream); else passed++;
    checks++; if (si_conv !== 1'b0)     $display("FAIL rst_si_conv: got %b want 0", si_conv); else passed++;
    checks++; if (state_next !== 8'h00) $display("FAIL rst_state_next: got %h want 00", state_next); else passed++;
    checks++; if (lcd_a0 !== 1'b0)      $display("FAIL rst_a0: got %b want 0", lcd_a0); else passed++;
    checks++; if (lcd_rst_n !== 1'b0)   $display("FAIL rst_lcd_rst_n: got %b want 0", lcd_rst_n); else passed++;
    checks++; if (pix_page !== 2'd0)    $display("FAIL rst_pix_page: got %0d want 0", pix_page); else passed++;
    checks++; if (pix_col !== 8'd0)     $display("FAIL rst_pix_col: got %0d want 0", pix_col); else passed++;
    checks++; if (busy !== 1'b1)        $display("FAIL rst_busy: got %b want 1", busy); else passed++;
    reset = 1'b0;
    check_boot("boot");
    $display("test_reset: boot sequence done, %0d bytes captured", cap_b.size());
  endtask

  task automatic test_frame();
    int start_exp, n, mm;
    bit ok;
    pix_mode = 1'b0;
    clear_caps();
    pulse_refresh(start_exp);
    wait_for(3, 6000, n, ok);
    checks++;
    if (!ok || cyc != start_exp + 4860) $display("FAIL frame_len: busy fell at %0d want %0d", cyc, start_exp + 4860); else passed++;
    checks++;
    if (cap_c.size() == 0 || cap_c[0] != start_exp)
      $display("FAIL frame_start: first byte at %0d want %0d", (cap_c.size() != 0) ? cap_c[0] : -1, start_exp);
    else passed++;
    build_frame(1'b0);
    mm = first_mismatch();
    checks++;
    if (mm >= 0)
      $display("FAIL frame_bytes: idx %0d got %h want %h (n %0d/%0d)", mm, cap_at(mm), exp_at(mm), cap_b.size(), exp_b.size());
    else passed++;
    mm = bad_spacing(0, 539);
    checks++;
    if (mm >= 0) $display("FAIL frame_spacing: idx %0d gap %0d want 9", mm, cap_c[mm] - cap_c[mm-1]); else passed++;
    checks++;
    if ({si_conv, pix_page, pix_col} !== {1'b0, 2'd0, 8'd0})
      $display("FAIL frame_end_addr: got si %b page %0d col %0d want 0 0 0", si_conv, pix_page, pix_col);
    else passed++;
    $display("test_frame: %0d bytes, busy fell at cycle %0d", cap_b.size(), cyc);
  endtask

  task automatic test_back_to_back();
    int start_exp, end1, n, mm;
    bit ok;
    pix_mode = 1'b1;
    clear_caps();
    pulse_refresh(start_exp);
    repeat (300)  @(negedge clock); refresh = 1'b1; @(negedge clock); refresh = 1'b0;
    repeat (1000) @(negedge clock); refresh = 1'b1; @(negedge clock); refresh = 1'b0;
    repeat (2000) @(negedge clock); refresh = 1'b1; @(negedge clock); refresh = 1'b0;
    wait_for(3, 6000, n, ok);
    end1 = cyc;
    checks++;
    if (!ok || end1 != start_exp + 4860) $display("FAIL b2b_frame1_len: end %0d want %0d", end1, start_exp + 4860); else passed++;
    @(posedge clock); #1;
    checks++;
    if ({si_conv, busy, stream} !== {1'b1, 1'b1, 8'hB0})
      $display("FAIL b2b_restart: got si %b busy %b stream %h want 1 1 b0", si_conv, busy, stream);
    else passed++;
    wait_for(3, 6000, n, ok);
    checks++;
    if (!ok || cyc != end1 + 1 + 4860) $display("FAIL b2b_frame2_len: end %0d want %0d", cyc, end1 + 4861); else passed++;
    repeat (30) @(posedge clock);
    #1;
    build_frame(1'b1);
    build_frame(1'b1);
    mm = first_mismatch();
    checks++;
    if (mm >= 0)
      $display("FAIL b2b_bytes: idx %0d got %h want %h (n %0d/%0d)", mm, cap_at(mm), exp_at(mm), cap_b.size(), exp_b.size());
    else passed++;
    checks++;
    if ({si_conv, busy} !== 2'b00) $display("FAIL b2b_no_third: got si %b busy %b want 0 0", si_conv, busy); else passed++;
    $display("test_back_to_back: %0d bytes over two frames", cap_b.size());
  endtask

  task automatic test_stall();
    int start_exp, n, mm;
    bit ok, found;
    logic [7:0] s_stream, s_col, s_sn;
    bit bad_stream, bad_col, bad_sn;
    pix_mode = 1'b0;
    clear_caps();
    pulse_refresh(start_exp);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clock);
      if (pix_page == 2'd1 && pix_col == 8'd60 && count == 4'd5) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL stall_reach: page %0d col %0d never reached 1/60", pix_page, pix_col); else passed++;
    stall = 1'b1;
    s_stream = stream; s_col = pix_col; s_sn = state_next;
    bad_stream = 1'b0; bad_col = 1'b0; bad_sn = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (stream !== s_stream) bad_stream = 1'b1;
      if (pix_col !== s_col)   bad_col = 1'b1;
      if (state_next !== s_sn) bad_sn = 1'b1;
    end
    stall = 1'b0;
    checks++; if (bad_stream) $display("FAIL stall_stream: got %h want %h", stream, s_stream); else passed++;
    checks++; if (bad_col)    $display("FAIL stall_pix_col: got %0d want %0d", pix_col, s_col); else passed++;
    checks++; if (bad_sn)     $display("FAIL stall_state_next: got %h want %h", state_next, s_sn); else passed++;
    wait_for(3, 6000, n, ok);
    checks++;
    if (!ok || cyc != start_exp + 4880) $display("FAIL stall_len: end %0d want %0d", cyc, start_exp + 4880); else passed++;
    build_frame(1'b0);
    mm = first_mismatch();
    checks++;
    if (mm >= 0)
      $display("FAIL stall_bytes: idx %0d got %h want %h (n %0d/%0d)", mm, cap_at(mm), exp_at(mm), cap_b.size(), exp_b.size());
    else passed++;
    $display("test_stall: %0d bytes with 20-cycle stall at page 1", cap_b.size());
  endtask

  task automatic test_reset_mid();
    int start_exp;
    bit found;
    pix_mode = 1'b0;
    clear_caps();
    pulse_refresh(start_exp);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clock);
      if (pix_page == 2'd2 && pix_col == 8'd51) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL rmid_reach: page %0d col %0d never reached 2/51", pix_page, pix_col); else passed++;
    refresh = 1'b1;
    @(negedge clock);
    refresh = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    checks++;
    if ({stream, si_conv, state_next, lcd_a0, lcd_rst_n, pix_page, pix_col, busy} !==
        {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1})
      $display("FAIL rmid_values: got %h %b %h %b %b %0d %0d %b want 00 0 00 0 0 0 0 1",
               stream, si_conv, state_next, lcd_a0, lcd_rst_n, pix_page, pix_col, busy);
    else passed++;
    reset = 1'b0;
    check_boot("rmid");
    repeat (30) @(posedge clock);
    #1;
    checks++;
    if (cap_b.size() != 12 || busy !== 1'b0)
      $display("FAIL rmid_pending_lost: got %0d bytes busy %b want 12 0", cap_b.size(), busy);
    else passed++;
    $display("test_reset_mid: init replayed, %0d bytes", cap_b.size());
  endtask

`ifdef LCD_SEQ_CONTRAST_EN
  task automatic test_contrast();
    int start_exp, n;
    bit ok;
    clear_caps();
    @(negedge clock);
    contrast  = 6'h2A;
    start_exp = cyc + 1;
    wait_for(3, 100, n, ok);
    checks++;
    if (!ok || cyc != start_exp + 18) $display("FAIL contr_len: end %0d want %0d", cyc, start_exp + 18); else passed++;
    push_exp(8'h81, 1'b0, 8'h05);
    push_exp(8'h2A, 1'b0, 8'h05);
    checks++;
    if (first_mismatch() >= 0 || cap_c.size() != 2 || cap_c[0] != start_exp)
      $display("FAIL contr_bytes: got n %0d first %h want 2 bytes 81 2a from %0d", cap_b.size(), cap_at(0), start_exp);
    else passed++;
    checks++;
    if ({si_conv, state_next} !== {1'b0, 8'h02}) $display("FAIL contr_idle: got si %b state %h want 0 02", si_conv, state_next); else passed++;
    $display("test_contrast: %0d bytes", cap_b.size());
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef LCD_SEQ_CONTRAST_EN
    test_contrast();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sequencer.md
# lcd_frame_sequencer

Byte-level sequencer for the bicycle computer's SPI LCD (ST7565-class controller, 132×32, 4 pages). It releases the panel from reset and sends the fixed init command list. On each `refresh` request it walks the framebuffer page by page, emitting page/column address commands followed by pixel data bytes. It sits directly upstream of the LCD parallel-to-serial converter: it drives `stream`, `si_conv` and `state_next` into it and paces itself on the converter's `count` output.

## Interface
- `COLS`, 132: data bytes per page.
- `PAGES`, 4: pages per frame; page index width 2 bits.
- `RST_CYCLES`, 10: clocks for panel reset pulse and for post-reset wait.

- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `refresh` in 1: one-cycle pulse requesting a full-frame redraw.
- `count` in 4: serializer bit counter; value 8 marks the last cycle of a byte slot.
- `pix_data` in 8: framebuffer byte at (`pix_page`, `pix_col`), valid ≤8 cycles after the address changes.
- `stream` out 8: byte currently offered to the serializer.
- `si_conv` out 1: serializer enable; high for the whole transfer sequence.
- `state_next` out 8: state code of the byte in `stream`; IDLE 8'h02, INIT 8'h01, ADDR 8'h03, WRITE 8'h04, CONTR 8'h05, RST 8'h00.
- `lcd_a0` out 1: 0 = command, 1 = display data; aligned with `stream`.
- `lcd_rst_n` out 1: panel reset, active-low.
- `pix_page` out 2, `pix_col` out 8: framebuffer read address.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: RST_HOLD → RST_WAIT → INIT → IDLE ⇄ {ADDR → WRITE}×PAGES → IDLE. With the contrast option compiled in, IDLE also goes to CONTR and back.
- RST_HOLD: `lcd_rst_n`=0 for RST_CYCLES clocks. RST_WAIT: `lcd_rst_n`=1, idle for RST_CYCLES clocks.
- INIT ROM, 12 command bytes in order: 40 A1 C0 A6 A2 2F F8 00 23 81 1F AF (hex). `lcd_a0`=0.
- ADDR: 3 commands per page: B0|page, 10, 00. `lcd_a0`=0.
- WRITE: COLS bytes from `pix_data`, col 0..COLS-1. `lcd_a0`=1.
- Byte handshake: the first byte is loaded together with `si_conv` 0→1. On every edge where `si_conv`=1 and `count`==8, the next byte, `lcd_a0` and `state_next` are loaded at that same edge. After the final byte of a sequence, `si_conv` drops to 0 at that edge.
- Sequences (INIT, frame, contrast) are each one continuous `si_conv` burst. There are no gaps between bytes.
- Prefetch: during a byte slot, `pix_page`/`pix_col` hold the address of the next data byte. `pix_data` is sampled at the `count`==8 edge.
- `refresh` during RST/INIT or a frame sets a single pending flag. The redraw starts from IDLE on the next cycle. Multiple pulses collapse into one.
- Page counter wraps after PAGES-1 to IDLE. Column counter clears at each page.

## Timing
- Reset values: `stream`=00, `si_conv`=0, `state_next`=8'h00, `lcd_a0`=0, `lcd_rst_n`=0, `pix_page`=0, `pix_col`=0, `busy`=1, pending=0.
- Byte slot = 9 clocks (`count` 0..8).
- INIT = 108 clocks. Frame = PAGES×(3+COLS)×9 = 4860 clocks at defaults.
- `refresh` in IDLE → `si_conv`=1 with `stream`=B0 on the next edge.
- `reset` mid-sequence: all outputs return to reset values at the next edge. The full RST/INIT sequence then repeats, and the pending flag is cleared.
- If `count`≠8 while `si_conv`=1 (serializer stalled), all outputs hold.

## Configuration
- `LCD_SEQ_CONTRAST_EN` defined: adds input `contrast` [5:0].
  - INIT byte 11 becomes `{2'b00,contrast}`.
  - A change of `contrast` seen in IDLE sends the burst 81, value (state CONTR, `lcd_a0`=0).
  - A change seen while busy is latched and sent after return to IDLE. A pending refresh has priority.
- Not defined: no port; byte 11 is fixed 1F; state CONTR is unreachable.

## Test plan
- Reset release: `lcd_rst_n` low 10 clocks, high; after a further 10 clocks, bytes 40…AF appear with `lcd_a0`=0, each held 9 clocks; `si_conv` falls after AF.
- Single refresh with `pix_data`=col index: stream B0 10 00 then 00..83 (`lcd_a0`=1), repeated with B1, B2, B3; `busy` falls after 4860 clocks.
- Refresh pulsed 3 times during a frame: exactly one further frame follows, starting the cycle after IDLE.
- Serializer model stalls `count` at 5 for 20 cycles mid-WRITE: `stream`, `pix_col` and `state_next` remain stable; no byte is skipped or duplicated.
- Reset asserted at page 2, col 50: next edge shows reset values; INIT replays; the pending refresh is lost.
- `LCD_SEQ_CONTRAST_EN`, `contrast` 1F→2A in IDLE: burst 81, 2A with `state_next`=8'h05, then IDLE.
